mem_stage: RTL

- Memory stage of the 5-stage pipeline; sits directly downstream of the execute stage and its EXE/MEM register.
- Takes the ALU result as the address and Val_Rm as store data, and performs word loads and stores on an internal data memory that has a fixed multi-cycle access latency.
- Drives Ready low to freeze the upstream pipeline while an access is in flight.
- Registers the write-back bundle into the MEM/WB register.

---
 rtl/mem_stage_if.sv | 26 ++
 rtl/mem_stage.sv | 109 ++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Bundle between the EXE/MEM register, the memory stage and the MEM/WB register.
// The upstream side (master) drives the *_In signals and obeys Ready.
interface mem_stage_if;
  logic        WB_En_In;
  logic        Mem_R_En_In;
  logic        Mem_W_En_In;
  logic [3:0]  Dest_In;
  logic [31:0] ALU_Res_In;
  logic [31:0] Val_Rm_In;
  logic        Ready;
  logic        WB_En_Out;
  logic        Mem_R_En_Out;
  logic [3:0]  Dest_Out;
  logic [31:0] ALU_Res_Out;
  logic [31:0] Mem_Data_Out;

  modport master (
    output WB_En_In, Mem_R_En_In, Mem_W_En_In, Dest_In, ALU_Res_In, Val_Rm_In,
    input  Ready, WB_En_Out, Mem_R_En_Out, Dest_Out, ALU_Res_Out, Mem_Data_Out
  );

  modport slave (
    input  WB_En_In, Mem_R_En_In, Mem_W_En_In, Dest_In, ALU_Res_In, Val_Rm_In,
    output Ready, WB_En_Out, Mem_R_En_Out, Dest_Out, ALU_Res_Out, Mem_Data_Out
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: word loads/stores on a fixed-latency data memory,
// stalling upstream via Ready, and registering the MEM/WB bundle.
module mem_stage #(
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 1024,
  parameter int LATENCY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] counter_q, counter_d;
  logic          wb_en_q, wb_en_d;
  logic          mem_r_en_q, mem_r_en_d;
  logic [3:0]    dest_q, dest_d;
  logic [31:0]   alu_res_q, alu_res_d;
  logic [31:0]   mem_data_q, mem_data_d;
  logic [31:0]   mem_q [DEPTH];

  logic          req;
  logic          ready;
  logic          wr_en;
  logic [AW-1:0] idx;

  assign req = bus.Mem_R_En_In | bus.Mem_W_En_In;
  // Byte offset from the base, word-aligned, wrapping modulo DEPTH.
  assign idx = AW'((bus.ALU_Res_In - 32'(BASE_ADDR)) >> 2);

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    wb_en_d    = wb_en_q;
    mem_r_en_d = mem_r_en_q;
    dest_d     = dest_q;
    alu_res_d  = alu_res_q;
    mem_data_d = mem_data_q;
    ready      = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!req) begin
          ready      = 1'b1;
          wb_en_d    = bus.WB_En_In;
          mem_r_en_d = bus.Mem_R_En_In;
          dest_d     = bus.Dest_In;
          alu_res_d  = bus.ALU_Res_In;
          mem_data_d = '0;
        end else begin
          counter_d = CNT_INIT;
          state_d   = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        counter_d = counter_q - CW'(1);
        if (counter_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        // Read sees the pre-write word when load and store coincide.
        ready      = 1'b1;
        wr_en      = bus.Mem_W_En_In;
        wb_en_d    = bus.WB_En_In;
        mem_r_en_d = bus.Mem_R_En_In;
        dest_d     = bus.Dest_In;
        alu_res_d  = bus.ALU_Res_In;
        mem_data_d = bus.Mem_R_En_In ? mem_q[idx] : '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      dest_q     <= '0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      dest_q     <= dest_d;
      alu_res_q  <= alu_res_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= bus.Val_Rm_In;
  end

  assign bus.Ready        = ready;
  assign bus.WB_En_Out    = wb_en_q;
  assign bus.Mem_R_En_Out = mem_r_en_q;
  assign bus.Dest_Out     = dest_q;
  assign bus.ALU_Res_Out  = alu_res_q;
  assign bus.Mem_Data_Out = mem_data_q;
endmodule
